// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Watches a multiplexed 7-segment bus (segment lines plus one-hot digit
// select) and rebuilds the BCD value shown on each digit. A digit is only
// committed after STABLE consecutive identical observations of that digit,
// so scan glitches and ghosting during digit changeover are filtered out.
// Patterns that are not legal digits commit as 4'hF with err set.

module seg7_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample,
    input  logic [0:6]           seg,
    input  logic [NDIG-1:0]      an,
    output logic [4*NDIG-1:0]    digits,
    output logic [NDIG-1:0]      err,
    output logic                 valid,
    output logic                 update
);

    localparam logic [3:0] STB = 4'(STABLE);

    logic [3:0]      obs_code;
    logic            obs_ill;
    logic            observe;

    logic [3:0]      cand_code [NDIG];
    logic [NDIG-1:0] cand_ill;
    logic [3:0]      cnt       [NDIG];
    logic [NDIG-1:0] seen;

    logic [NDIG-1:0] match;
    logic [NDIG-1:0] commit_mask;
    logic [NDIG-1:0] changed;

    // Only a strobed edge with exactly one digit selected is a usable observation
    assign observe = sample && $onehot(an);

    // Segment pattern to BCD; anything unrecognised (including blank) is illegal
    always_comb begin
        obs_code = 4'hF;
        obs_ill  = 1'b1;
        case (seg)
            7'b1111110:             begin obs_code = 4'd0; obs_ill = 1'b0; end
            7'b0110000:             begin obs_code = 4'd1; obs_ill = 1'b0; end
            7'b1101101:             begin obs_code = 4'd2; obs_ill = 1'b0; end
            7'b1111001:             begin obs_code = 4'd3; obs_ill = 1'b0; end
            7'b0110011:             begin obs_code = 4'd4; obs_ill = 1'b0; end
            7'b1011011:             begin obs_code = 4'd5; obs_ill = 1'b0; end
            7'b1011111, 7'b0011111: begin obs_code = 4'd6; obs_ill = 1'b0; end
            7'b1110000, 7'b1110010: begin obs_code = 4'd7; obs_ill = 1'b0; end
            7'b1111111:             begin obs_code = 4'd8; obs_ill = 1'b0; end
            7'b1111011, 7'b1110011: begin obs_code = 4'd9; obs_ill = 1'b0; end
            default:                begin obs_code = 4'hF; obs_ill = 1'b1; end
        endcase
    end

    // Per-digit run tracking: commit on the edge the run reaches STABLE, never again while saturated
    always_comb begin
        match       = '0;
        commit_mask = '0;
        changed     = '0;
        for (int i = 0; i < NDIG; i++) begin
            match[i] = (cand_code[i] == obs_code) && (cand_ill[i] == obs_ill);
            if (observe && an[i]) begin
                if (match[i]) begin
                    commit_mask[i] = (cnt[i] == STB - 4'd1);
                end else begin
                    commit_mask[i] = (STB == 4'd1);
                end
                changed[i] = commit_mask[i] &&
                             (!seen[i] || (digits[4*i +: 4] != obs_code) || (err[i] != obs_ill));
            end
        end
    end

    // Candidate/counter filter state plus committed outputs, update pulse and sticky valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits   <= '1;
            err      <= '0;
            valid    <= 1'b0;
            update   <= 1'b0;
            seen     <= '0;
            cand_ill <= '0;
            for (int i = 0; i < NDIG; i++) begin
                cand_code[i] <= 4'hF;
                cnt[i]       <= 4'd0;
            end
        end else begin
            update <= |changed;
            seen   <= seen | commit_mask;
            if (&(seen | commit_mask)) begin
                valid <= 1'b1;
            end
            for (int i = 0; i < NDIG; i++) begin
                if (observe && an[i]) begin
                    if (match[i]) begin
                        if (cnt[i] != STB) begin
                            cnt[i] <= cnt[i] + 4'd1;
                        end
                    end else begin
                        cand_code[i] <= obs_code;
                        cand_ill[i]  <= obs_ill;
                        cnt[i]       <= 4'd1;
                    end
                    if (commit_mask[i]) begin
                        digits[4*i +: 4] <= obs_code;
                        err[i]           <= obs_ill;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios followed by randomized
// scanning, every cycle compared against a history-based reference model.

module tb_seg7_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    logic                 clk;
    logic                 reset;
    logic                 sample;
    logic [0:6]           seg;
    logic [NDIG-1:0]      an;
    logic [4*NDIG-1:0]    digits;
    logic [NDIG-1:0]      err;
    logic                 valid;
    logic                 update;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk    (clk),
        .reset  (reset),
        .sample (sample),
        .seg    (seg),
        .an     (an),
        .digits (digits),
        .err    (err),
        .valid  (valid),
        .update (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // patterns written a..g, leftmost bit is segment a
    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                           P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                           P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                           P9 = 7'b1111011, P7B = 7'b1110010, P9B = 7'b1110011,
                           P6B = 7'b0011111, BLANK = 7'b0000000;

    logic [6:0] tbl_pat [13] = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9, P6B, P7B, P9B};
    logic [3:0] tbl_val [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                                 4'd6, 4'd7, 4'd9};

    int checks   = 0;
    int failures = 0;
    int upd_cnt  = 0;
    bit cmp_en   = 1'b1;

    // reference model: per-digit observation history
    logic [4:0]      hist [NDIG][$];
    logic [3:0]      m_dig  [NDIG];
    logic [NDIG-1:0] m_err;
    logic [NDIG-1:0] m_seen;
    logic            m_valid;
    logic            m_update;

    function automatic logic [4:0] decode(input logic [6:0] p);
        for (int k = 0; k < 13; k++)
            if (tbl_pat[k] == p) return {tbl_val[k], 1'b0};
        return {4'hF, 1'b1};
    endfunction

    function automatic logic [4*NDIG-1:0] m_digits();
        logic [4*NDIG-1:0] v;
        for (int k = 0; k < NDIG; k++) v[4*k +: 4] = m_dig[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDIG; k++) begin
            hist[k].delete();
            m_dig[k] = 4'hF;
        end
        m_err = '0; m_seen = '0; m_valid = 1'b0; m_update = 1'b0;
    endtask

    // commit when the last STABLE observations agree and the run is exactly STABLE long
    task automatic model_step(input logic s, input logic [NDIG-1:0] a, input logic [6:0] p);
        int idx, n;
        logic [4:0] o;
        bit run;
        m_update = 1'b0;
        if (!s || $countones(a) != 1) return;
        idx = 0;
        for (int k = 0; k < NDIG; k++) if (a[k]) idx = k;
        o = decode(p);
        hist[idx].push_back(o);
        if (hist[idx].size() > STABLE + 1) void'(hist[idx].pop_front());
        n = hist[idx].size();
        if (n < STABLE) return;
        run = 1'b1;
        for (int k = n - STABLE; k < n; k++) if (hist[idx][k] != o) run = 1'b0;
        if (n > STABLE && hist[idx][n-STABLE-1] == o) run = 1'b0;
        if (!run) return;
        if (!m_seen[idx] || m_dig[idx] != o[4:1] || m_err[idx] != o[0]) m_update = 1'b1;
        m_dig[idx]  = o[4:1];
        m_err[idx]  = o[0];
        m_seen[idx] = 1'b1;
        if (&m_seen) m_valid = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("digits", 32'(digits), 32'(m_digits()));
        chk("err",    32'(err),    32'(m_err));
        chk("valid",  32'(valid),  32'(m_valid));
        chk("update", 32'(update), 32'(m_update));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(sample, an, seg);
        #1;
        if (cmp_en) compare_all();
        if (update === 1'b1) upd_cnt++;
    endtask

    task automatic drive(input logic s, input logic [NDIG-1:0] a, input logic [6:0] p);
        sample = s; an = a; seg = p;
        tick();
    endtask

    task automatic obs(input int d, input logic [6:0] p);
        drive(1'b1, NDIG'(1) << d, p);
    endtask

    task automatic scan(input logic [6:0] p3, input logic [6:0] p2,
                        input logic [6:0] p1, input logic [6:0] p0);
        obs(3, p3); obs(2, p2); obs(1, p1); obs(0, p0);
    endtask

    task automatic async_reset_check(input string nm);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk({nm, "_digits"}, 32'(digits), 32'h0000FFFF);
        chk({nm, "_err"},    32'(err),    32'h0);
        chk({nm, "_valid"},  32'(valid),  32'h0);
        chk({nm, "_update"}, 32'(update), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b0;
    endtask

    logic [6:0] cur [NDIG];

    initial begin
        sample = 1'b0; an = '0; seg = BLANK; reset = 1'b0;
        model_reset();
        async_reset_check("rst0");

        // basic commit: 1,2,3,4 on digits 3..0
        upd_cnt = 0;
        for (int r = 0; r < 3; r++) begin
            if (r == 2) begin
                obs(3, P1); obs(2, P2); obs(1, P3);
                chk("valid_before_last", 32'(valid), 32'h0);
                obs(0, P4);
            end else begin
                scan(P1, P2, P3, P4);
            end
        end
        chk("basic_digits", 32'(digits), 32'h1234);
        chk("basic_valid",  32'(valid),  32'h1);
        chk("basic_upd",    32'(upd_cnt), 32'd4);

        // glitch on digit 0
        upd_cnt = 0;
        obs(0, P5);
        for (int r = 0; r < 3; r++) scan(P1, P2, P3, P4);
        chk("glitch_digits", 32'(digits), 32'h1234);
        chk("glitch_upd",    32'(upd_cnt), 32'd0);

        // digit 2 changes to 7, then alternate 7 pattern
        upd_cnt = 0;
        for (int r = 0; r < 3; r++) scan(P1, P7, P3, P4);
        chk("chg7_digits", 32'(digits), 32'h1734);
        chk("chg7_upd",    32'(upd_cnt), 32'd1);
        upd_cnt = 0;
        for (int r = 0; r < 3; r++) scan(P1, P7B, P3, P4);
        chk("alt7_digits", 32'(digits), 32'h1734);
        chk("alt7_upd",    32'(upd_cnt), 32'd0);

        // blank on digit 1, then alternate 9
        upd_cnt = 0;
        for (int r = 0; r < 3; r++) scan(P1, P7, BLANK, P4);
        chk("blank_digits", 32'(digits), 32'h17F4);
        chk("blank_err",    32'(err),    32'b0010);
        chk("blank_upd",    32'(upd_cnt), 32'd1);
        upd_cnt = 0;
        for (int r = 0; r < 3; r++) scan(P1, P7, P9B, P4);
        chk("nine_digits", 32'(digits), 32'h1794);
        chk("nine_err",    32'(err),    32'b0000);
        chk("nine_upd",    32'(upd_cnt), 32'd1);

        // ignored edges interleaved in a run on digit 0
        obs(0, P8);
        drive(1'b1, 4'b0000, P8);
        obs(0, P8);
        drive(1'b1, 4'b0101, P8);
        drive(1'b0, 4'b0001, P8);
        drive(1'b0, 4'b0001, P8);
        chk("ign_hold", 32'(digits), 32'h1794);
        obs(0, P8);
        chk("ign_commit", 32'(digits), 32'h1798);

        // randomized scanning with a mid-run reset
        for (int k = 0; k < NDIG; k++) cur[k] = tbl_pat[$urandom_range(0, 12)];
        for (int c = 0; c < 2000; c++) begin
            logic [NDIG-1:0] a;
            logic [6:0] p;
            int d;
            if (c == 1000) begin
                cmp_en = 1'b0;
                async_reset_check("rst_mid");
                cmp_en = 1'b1;
            end
            d = $urandom_range(0, NDIG - 1);
            if ($urandom_range(0, 99) < 85) a = NDIG'(1) << d;
            else a = NDIG'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 3) == 0) cur[d] = 7'($urandom);
                else cur[d] = tbl_pat[$urandom_range(0, 12)];
            end
            p = cur[d];
            if ($urandom_range(0, 29) == 0) p = 7'($urandom);
            drive(($urandom_range(0, 7) != 0), a, p);
        end
        chk("rand_valid_end", 32'(valid), 32'(m_valid));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
